// File: rtl/eth_frame_parser.sv
// eth_frame_parser
// Byte-wide GMII receive parser. It checks the preamble and SFD, then captures
// DA, SA, up to MAX_VLAN_TAGS VLAN TCIs and the inner EtherType, and streams
// the rest of the frame (payload + FCS) with a last marker. At end of frame it
// reports the length and the error status.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rx_valid, rx_data, rx_er          GMII receive (RX_DV, RXD, RX_ER)
//   hdr_valid                         one-cycle pulse, header outputs updated
//   dst_mac, src_mac                  first received byte in [47:40]
//   ether_type, vlan_count, vlan_tci  inner type, tag count, TCIs (outer tag low)
//   pay_valid, pay_data, pay_last     payload/FCS stream
//   frame_done, frame_len             end-of-frame pulse and DA..last byte count
//   err_preamble/short/long/rx        error flags, meaningful with frame_done
module eth_frame_parser #(
  parameter int MAX_VLAN_TAGS   = 2,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int LEN_W           = $clog2(MAX_FRAME_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 rx_er,
  output logic                 hdr_valid,
  output logic [47:0]          dst_mac,
  output logic [47:0]          src_mac,
  output logic [15:0]          ether_type,
  output logic [1:0]           vlan_count,
  output logic [16*((MAX_VLAN_TAGS > 0) ? MAX_VLAN_TAGS : 1)-1:0] vlan_tci,
  output logic                 pay_valid,
  output logic [7:0]           pay_data,
  output logic                 pay_last,
  output logic                 frame_done,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 err_preamble,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_rx
);

  // With MAX_VLAN_TAGS=0 one unused TCI slot is kept so the port stays legal.
  localparam int unsigned      TAG_SLOTS = (MAX_VLAN_TAGS > 0) ? MAX_VLAN_TAGS : 1;
  localparam int unsigned      TCI_W     = 16 * TAG_SLOTS;
  localparam logic [1:0]       TAG_LIMIT = 2'(MAX_VLAN_TAGS);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_FRAME_BYTES);
  localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(MIN_FRAME_BYTES);

  typedef enum logic [3:0] {
    IDLE, PRE, SFD, DST, SRC, TYPE, TCI, PAY, DROP
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [47:0]      r_dst;
  logic [47:0]      r_src;
  logic [7:0]       r_hi;
  logic [1:0]       r_vcnt;
  logic [15:0]      r_tci [TAG_SLOTS];
  logic [7:0]       r_hold;
  logic             r_hold_v;
  logic             r_err_pre;
  logic             r_err_long;
  logic             r_err_rx;

  logic [15:0]      w_type;
  logic             w_tpid;
  logic             w_end;
  logic             w_short;
  logic [TCI_W-1:0] w_tci_packed;

  always_comb begin
    w_type       = {r_hi, rx_data};
    w_tpid       = ((w_type == 16'h8100) || (w_type == 16'h88A8)) && (r_vcnt < TAG_LIMIT);
    // Any non-idle state ends the frame on the first cycle without rx_valid.
    w_end        = !rx_valid && (r_state != IDLE);
    // Truncated headers are short; a preamble failure never counted bytes,
    // so it is not additionally flagged as short.
    w_short      = (r_state inside {PRE, SFD, DST, SRC, TYPE, TCI}) ||
                   (!r_err_pre && (r_len < LEN_MIN));
    w_tci_packed = '0;
    for (int unsigned i = 0; i < TAG_SLOTS; i++) begin
      w_tci_packed[16*i +: 16] = r_tci[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_dst        <= '0;
      r_src        <= '0;
      r_hi         <= '0;
      r_vcnt       <= '0;
      r_hold       <= '0;
      r_hold_v     <= 1'b0;
      r_err_pre    <= 1'b0;
      r_err_long   <= 1'b0;
      r_err_rx     <= 1'b0;
      for (int unsigned i = 0; i < TAG_SLOTS; i++) r_tci[i] <= '0;
      hdr_valid    <= 1'b0;
      dst_mac      <= '0;
      src_mac      <= '0;
      ether_type   <= '0;
      vlan_count   <= '0;
      vlan_tci     <= '0;
      pay_valid    <= 1'b0;
      pay_data     <= '0;
      pay_last     <= 1'b0;
      frame_done   <= 1'b0;
      frame_len    <= '0;
      err_preamble <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_rx       <= 1'b0;
    end else begin
      hdr_valid    <= 1'b0;
      pay_valid    <= 1'b0;
      pay_last     <= 1'b0;
      frame_done   <= 1'b0;
      err_preamble <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_rx       <= 1'b0;

      if (rx_valid && rx_er) r_err_rx <= 1'b1;

      case (r_state)
        IDLE: if (rx_valid) begin
          // This byte is preamble byte 1; PRE then checks bytes 2..7.
          r_cnt      <= '0;
          r_len      <= '0;
          r_vcnt     <= '0;
          r_hold_v   <= 1'b0;
          r_err_rx   <= rx_er;
          r_err_long <= 1'b0;
          for (int unsigned i = 0; i < TAG_SLOTS; i++) r_tci[i] <= '0;
          if (rx_data == 8'h55) begin
            r_err_pre <= 1'b0;
            r_state   <= PRE;
          end else begin
            r_err_pre <= 1'b1;
            r_state   <= DROP;
          end
        end
        PRE: if (rx_valid) begin
          if (rx_data != 8'h55) begin
            r_err_pre <= 1'b1;
            r_state   <= DROP;
            r_cnt     <= '0;
          end else if (r_cnt == 3'd5) begin
            r_state <= SFD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        SFD: if (rx_valid) begin
          r_cnt <= '0;
          if (rx_data == 8'hD5) begin
            r_state <= DST;
          end else begin
            r_err_pre <= 1'b1;
            r_state   <= DROP;
          end
        end
        DST, SRC: if (rx_valid) begin
          r_len <= r_len + LEN_W'(1);
          if (r_state == DST) r_dst <= {r_dst[39:0], rx_data};
          else                r_src <= {r_src[39:0], rx_data};
          if (r_cnt == 3'd5) begin
            r_state <= (r_state == DST) ? SRC : TYPE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        TYPE: if (rx_valid) begin
          r_len <= r_len + LEN_W'(1);
          if (r_cnt == 3'd0) begin
            r_hi  <= rx_data;
            r_cnt <= 3'd1;
          end else begin
            r_cnt <= '0;
            if (w_tpid) begin
              r_state <= TCI;
            end else begin
              ether_type <= w_type;
              dst_mac    <= r_dst;
              src_mac    <= r_src;
              vlan_count <= r_vcnt;
              vlan_tci   <= w_tci_packed;
              hdr_valid  <= 1'b1;
              r_hold_v   <= 1'b0;
              r_state    <= PAY;
            end
          end
        end
        TCI: if (rx_valid) begin
          r_len <= r_len + LEN_W'(1);
          if (r_cnt == 3'd0) begin
            r_hi  <= rx_data;
            r_cnt <= 3'd1;
          end else begin
            for (int unsigned i = 0; i < TAG_SLOTS; i++) begin
              if (r_vcnt == 2'(i)) r_tci[i] <= {r_hi, rx_data};
            end
            r_vcnt  <= r_vcnt + 2'd1;
            r_cnt   <= '0;
            r_state <= TYPE;
          end
        end
        PAY: begin
          // One byte is held back so the final byte can carry pay_last once
          // rx_valid drops (or the length limit is hit).
          if (rx_valid) begin
            if (r_len == LEN_MAX) begin
              r_err_long <= 1'b1;
              if (r_hold_v) begin
                pay_valid <= 1'b1;
                pay_data  <= r_hold;
                pay_last  <= 1'b1;
              end
              r_hold_v <= 1'b0;
              r_cnt    <= '0;
              r_state  <= DROP;
            end else begin
              r_len <= r_len + LEN_W'(1);
              if (r_hold_v) begin
                pay_valid <= 1'b1;
                pay_data  <= r_hold;
              end
              r_hold   <= rx_data;
              r_hold_v <= 1'b1;
            end
          end else if (r_hold_v) begin
            pay_valid <= 1'b1;
            pay_data  <= r_hold;
            pay_last  <= 1'b1;
            r_hold_v  <= 1'b0;
          end
        end
        DROP: ;
        default: r_state <= IDLE;
      endcase

      if (w_end) begin
        frame_done   <= 1'b1;
        frame_len    <= r_len;
        err_preamble <= r_err_pre;
        err_short    <= w_short;
        err_long     <= r_err_long;
        err_rx       <= r_err_rx;
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_err_pre    <= 1'b0;
        r_err_long   <= 1'b0;
        r_err_rx     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_parser.sv
// Scoreboard bench for eth_frame_parser: expectations are queued as frames are
// built, monitors queue what the DUTs emit, and each test compares the two.
module tb_eth_frame_parser;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    logic [1:0]  vc;
    logic [31:0] tci;
  } hdr_t;
  typedef struct packed { logic [7:0] d; logic l; } pay_t;
  typedef struct packed { logic [10:0] len; logic pre; logic sh; logic lg; logic rx; } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_er;
  logic [7:0]  rx_data;

  logic        hdr_valid, pay_valid, pay_last, frame_done;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ether_type;
  logic [1:0]  vlan_count;
  logic [31:0] vlan_tci;
  logic [7:0]  pay_data;
  logic [10:0] frame_len;
  logic        err_preamble, err_short, err_long, err_rx;

  logic        z_hdr_valid, z_pay_valid, z_pay_last, z_done;
  logic [47:0] z_dst, z_src;
  logic [15:0] z_type, z_tci;
  logic [1:0]  z_vc;
  logic [7:0]  z_pay_data;
  logic [10:0] z_len;
  logic        z_ep, z_es, z_el, z_er;

  eth_frame_parser #(.MAX_VLAN_TAGS(2), .MIN_FRAME_BYTES(64), .MAX_FRAME_BYTES(1522)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_er(rx_er),
    .hdr_valid(hdr_valid), .dst_mac(dst_mac), .src_mac(src_mac), .ether_type(ether_type),
    .vlan_count(vlan_count), .vlan_tci(vlan_tci), .pay_valid(pay_valid), .pay_data(pay_data),
    .pay_last(pay_last), .frame_done(frame_done), .frame_len(frame_len),
    .err_preamble(err_preamble), .err_short(err_short), .err_long(err_long), .err_rx(err_rx));

  eth_frame_parser #(.MAX_VLAN_TAGS(0), .MIN_FRAME_BYTES(64), .MAX_FRAME_BYTES(1522)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_er(rx_er),
    .hdr_valid(z_hdr_valid), .dst_mac(z_dst), .src_mac(z_src), .ether_type(z_type),
    .vlan_count(z_vc), .vlan_tci(z_tci), .pay_valid(z_pay_valid), .pay_data(z_pay_data),
    .pay_last(z_pay_last), .frame_done(z_done), .frame_len(z_len),
    .err_preamble(z_ep), .err_short(z_es), .err_long(z_el), .err_rx(z_er));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = -1;
  int fall_cyc = 0;

  hdr_t  exp_hdr[$], got_hdr[$], exp0_hdr[$], got0_hdr[$];
  pay_t  exp_pay[$], got_pay[$], exp0_pay[$], got0_pay[$];
  done_t exp_done[$], got_done[$];
  logic [7:0] body[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid) got_hdr.push_back(hdr_t'({dst_mac, src_mac, ether_type, vlan_count, vlan_tci}));
      if (pay_valid) got_pay.push_back(pay_t'({pay_data, pay_last}));
      if (frame_done) begin
        got_done.push_back(done_t'({frame_len, err_preamble, err_short, err_long, err_rx}));
        done_cyc = cyc;
      end
      if (z_hdr_valid) got0_hdr.push_back(hdr_t'({z_dst, z_src, z_type, z_vc, 16'h0000, z_tci}));
      if (z_pay_valid) got0_pay.push_back(pay_t'({z_pay_data, z_pay_last}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic flush();
    exp_hdr.delete(); got_hdr.delete(); exp0_hdr.delete(); got0_hdr.delete();
    exp_pay.delete(); got_pay.delete(); exp0_pay.delete(); got0_pay.delete();
    exp_done.delete(); got_done.delete();
  endtask

  task automatic start_body();
    body.delete();
    for (int i = 1; i <= 6; i++) body.push_back(8'(i));
    for (int i = 10; i <= 15; i++) body.push_back(8'(i));
  endtask

  task automatic put16(input logic [15:0] v);
    body.push_back(v[15:8]);
    body.push_back(v[7:0]);
  endtask

  task automatic put_pay(input int n, input int seed);
    for (int i = 0; i < n; i++) body.push_back(8'(seed + 3 * i));
  endtask

  task automatic expect_pay(input int from, input int to);
    for (int i = from; i < to; i++) exp_pay.push_back(pay_t'({body[i], 1'(i == to - 1)}));
  endtask

  task automatic send(input logic [7:0] sfd, input int er_idx);
    for (int i = 0; i < 8 + body.size(); i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = (i < 7) ? 8'h55 : (i == 7) ? sfd : body[i - 8];
      rx_er    = (i == er_idx);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    fall_cyc = cyc;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (got_done.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    done_t ed, gd;
    rst = 1'b1; rx_valid = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({hdr_valid, dst_mac, src_mac, ether_type, vlan_count, vlan_tci, pay_valid, pay_data,
         pay_last, frame_done, frame_len, err_preamble, err_short, err_long, err_rx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got hdr=%b pay=%b done=%b len=%0d errs=%b%b%b%b exp all zero",
               hdr_valid, pay_valid, frame_done, frame_len, err_preamble, err_short, err_long, err_rx);
    end
    // Reset in the middle of a frame while rx_valid stays high.
    flush();
    start_body(); put16(16'h0800); put_pay(50, 8'h20);
    exp_done.push_back(done_t'({11'd0, 4'b1000}));
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : body[i - 8];
      rst      = (i == 18 || i == 19);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
    fall_cyc = cyc;
    wait_done(1);
    checks++;
    if (got_done.size() != 1 || got_hdr.size() != 0 || got_pay.size() != 0) begin
      errors++;
      $display("FAIL reset_midframe_events got done=%0d hdr=%0d pay=%0d exp 1/0/0",
               got_done.size(), got_hdr.size(), got_pay.size());
    end
    ed = exp_done.pop_front();
    gd = (got_done.size() > 0) ? got_done.pop_front() : done_t'('x);
    checks++;
    if (gd !== ed) begin errors++; $display("FAIL reset_midframe_done got=%h exp=%h", gd, ed); end
    checks++;
    if (done_cyc != fall_cyc + 1) begin
      errors++; $display("FAIL reset_midframe_timing got=%0d exp=%0d", done_cyc, fall_cyc + 1);
    end
  endtask

  task automatic test_frames(input string name, input int kind);
    hdr_t eh, gh; pay_t ep, gp; done_t ed, gd;
    int er_idx;
    flush();
    er_idx = -1;
    // kind 0: untagged, 1: QinQ, 2: rx_er mid payload, 3: back-to-back untagged + QinQ
    if (kind == 0 || kind == 2 || kind == 3) begin
      start_body(); put16(16'h0800); put_pay(50, 8'h20);
      exp_hdr.push_back(hdr_t'({48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 2'd0, 32'h0}));
      expect_pay(14, body.size());
      if (kind == 2) er_idx = 8 + 30;
      exp_done.push_back(done_t'({11'd64, 3'b000, 1'(kind == 2)}));
      send(8'hD5, er_idx);
    end
    if (kind == 1 || kind == 3) begin
      start_body(); put16(16'h88A8); put16(16'h0064); put16(16'h8100); put16(16'h2005);
      put16(16'h86DD); put_pay(50, 8'h40);
      exp_hdr.push_back(hdr_t'({48'h010203040506, 48'h0A0B0C0D0E0F, 16'h86DD, 2'd2, 32'h2005_0064}));
      expect_pay(22, body.size());
      exp_done.push_back(done_t'({11'd72, 4'b0000}));
      send(8'hD5, -1);
    end
    wait_done(exp_done.size());
    while (exp_hdr.size() > 0) begin
      eh = exp_hdr.pop_front();
      gh = (got_hdr.size() > 0) ? got_hdr.pop_front() : hdr_t'('x);
      checks++;
      if (gh !== eh) begin errors++; $display("FAIL %s_hdr got=%h exp=%h", name, gh, eh); end
    end
    while (exp_pay.size() > 0) begin
      ep = exp_pay.pop_front();
      gp = (got_pay.size() > 0) ? got_pay.pop_front() : pay_t'('x);
      checks++;
      if (gp !== ep) begin errors++; $display("FAIL %s_pay got=%h exp=%h", name, gp, ep); end
    end
    while (exp_done.size() > 0) begin
      ed = exp_done.pop_front();
      gd = (got_done.size() > 0) ? got_done.pop_front() : done_t'('x);
      checks++;
      if (gd !== ed) begin errors++; $display("FAIL %s_done got=%h exp=%h", name, gd, ed); end
    end
    checks++;
    if (got_hdr.size() + got_pay.size() + got_done.size() != 0) begin
      errors++;
      $display("FAIL %s_extra got hdr=%0d pay=%0d done=%0d exp 0", name,
               got_hdr.size(), got_pay.size(), got_done.size());
    end
  endtask

  task automatic test_no_vlan_param();
    hdr_t eh, gh; pay_t ep, gp; done_t ed, gd;
    flush();
    start_body(); put16(16'h8100); put16(16'h0123); put16(16'h0800); put_pay(50, 8'h60);
    exp0_hdr.push_back(hdr_t'({48'h010203040506, 48'h0A0B0C0D0E0F, 16'h8100, 2'd0, 32'h0}));
    for (int i = 14; i < body.size(); i++)
      exp0_pay.push_back(pay_t'({body[i], 1'(i == body.size() - 1)}));
    exp_hdr.push_back(hdr_t'({48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 2'd1, 32'h0000_0123}));
    exp_done.push_back(done_t'({11'd68, 4'b0000}));
    send(8'hD5, -1);
    wait_done(1);
    eh = exp0_hdr.pop_front();
    gh = (got0_hdr.size() > 0) ? got0_hdr.pop_front() : hdr_t'('x);
    checks++;
    if (gh !== eh) begin errors++; $display("FAIL notag_hdr got=%h exp=%h", gh, eh); end
    checks++;
    if (got0_pay.size() != exp0_pay.size()) begin
      errors++; $display("FAIL notag_pay_count got=%0d exp=%0d", got0_pay.size(), exp0_pay.size());
    end
    while (exp0_pay.size() > 0) begin
      ep = exp0_pay.pop_front();
      gp = (got0_pay.size() > 0) ? got0_pay.pop_front() : pay_t'('x);
      checks++;
      if (gp !== ep) begin errors++; $display("FAIL notag_pay got=%h exp=%h", gp, ep); end
    end
    eh = exp_hdr.pop_front();
    gh = (got_hdr.size() > 0) ? got_hdr.pop_front() : hdr_t'('x);
    checks++;
    if (gh !== eh) begin errors++; $display("FAIL onetag_hdr got=%h exp=%h", gh, eh); end
    ed = exp_done.pop_front();
    gd = (got_done.size() > 0) ? got_done.pop_front() : done_t'('x);
    checks++;
    if (gd !== ed) begin errors++; $display("FAIL onetag_done got=%h exp=%h", gd, ed); end
    checks++;
    if (got_pay.size() != 50) begin
      errors++; $display("FAIL onetag_pay_count got=%0d exp=50", got_pay.size());
    end
  endtask

  // Frames with no header/payload output: bad SFD (kind 0) and truncated SA (kind 1).
  task automatic test_aborted(input string name, input int kind);
    done_t ed, gd;
    flush();
    start_body();
    if (kind == 0) begin
      put16(16'h0800); put_pay(20, 8'h11);
      exp_done.push_back(done_t'({11'd0, 4'b1000}));
      send(8'hD4, -1);
    end else begin
      repeat (3) void'(body.pop_back());
      exp_done.push_back(done_t'({11'd9, 4'b0100}));
      send(8'hD5, -1);
    end
    wait_done(1);
    ed = exp_done.pop_front();
    gd = (got_done.size() > 0) ? got_done.pop_front() : done_t'('x);
    checks++;
    if (gd !== ed) begin errors++; $display("FAIL %s_done got=%h exp=%h", name, gd, ed); end
    checks++;
    if (done_cyc != fall_cyc + 1) begin
      errors++; $display("FAIL %s_timing got=%0d exp=%0d", name, done_cyc, fall_cyc + 1);
    end
    checks++;
    if (got_hdr.size() + got_pay.size() + got_done.size() != 0) begin
      errors++;
      $display("FAIL %s_extra got hdr=%0d pay=%0d done=%0d exp 0", name,
               got_hdr.size(), got_pay.size(), got_done.size());
    end
  endtask

  task automatic test_long();
    hdr_t eh, gh; pay_t ep, gp; done_t ed, gd;
    int bad = 0;
    flush();
    start_body(); put16(16'h0800); put_pay(1586, 8'h05);
    exp_hdr.push_back(hdr_t'({48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 2'd0, 32'h0}));
    expect_pay(14, 14 + 1508);
    exp_done.push_back(done_t'({11'd1522, 4'b0010}));
    send(8'hD5, -1);
    wait_done(1);
    eh = exp_hdr.pop_front();
    gh = (got_hdr.size() > 0) ? got_hdr.pop_front() : hdr_t'('x);
    checks++;
    if (gh !== eh) begin errors++; $display("FAIL long_hdr got=%h exp=%h", gh, eh); end
    while (exp_pay.size() > 0) begin
      ep = exp_pay.pop_front();
      gp = (got_pay.size() > 0) ? got_pay.pop_front() : pay_t'('x);
      checks++;
      if (gp !== ep) begin
        errors++;
        if (bad++ < 8) $display("FAIL long_pay got=%h exp=%h", gp, ep);
      end
    end
    ed = exp_done.pop_front();
    gd = (got_done.size() > 0) ? got_done.pop_front() : done_t'('x);
    checks++;
    if (gd !== ed) begin errors++; $display("FAIL long_done got=%h exp=%h", gd, ed); end
    checks++;
    if (done_cyc != fall_cyc + 1) begin
      errors++; $display("FAIL long_timing got=%0d exp=%0d", done_cyc, fall_cyc + 1);
    end
    checks++;
    if (got_pay.size() + got_done.size() != 0) begin
      errors++; $display("FAIL long_extra got pay=%0d done=%0d exp 0", got_pay.size(), got_done.size());
    end
  endtask

  initial begin
    test_reset();
    test_frames("untagged", 0);
    test_frames("qinq", 1);
    test_no_vlan_param();
    test_aborted("bad_sfd", 0);
    test_aborted("short", 1);
    test_long();
    test_frames("back_to_back", 3);
    test_frames("rx_er", 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
